// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Request/response bundle between the execute stage and the
//               RV32M multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, flush, Funct3, SrcA, SrcB,
        input  busy, done, Result
    );

    modport slave (
        input  start, flush, Funct3, SrcA, SrcB,
        output busy, done, Result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M sequencer: shift-add multiply and restoring
//               divide sharing one XLEN-bit adder. Optional macro
//               MULDIV_EARLY_OUT_EN skips the iteration for trivial cases.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input wire                clk,
    input wire                reset_n,
    muldiv_sequencer_if.slave bus
);

    localparam int c_CW = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PREP = 3'd1;
    localparam logic [2:0] c_CALC = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_mplr;
    logic [2*XLEN-1:0] r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_dz;
    logic [XLEN-1:0]   r_result;

    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_b_zero;
    logic              w_early;
    logic [2*XLEN-1:0] w_init_acc;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_add_x;
    logic [XLEN-1:0]   w_add_y;
    logic              w_add_ci;
    logic [XLEN:0]     w_sum;
    logic              w_no_borrow;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_acc_neg;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    // Funct3[2] selects divide; Funct3[0] marks the unsigned divide variants.
    assign w_is_div   = r_op[2];
    assign w_a_signed = w_is_div ? ~r_op[0] : (r_op[1:0] == 2'b01) || (r_op[1:0] == 2'b10);
    assign w_b_signed = w_is_div ? ~r_op[0] : (r_op[1:0] == 2'b01);
    assign w_sa       = w_a_signed & r_a[XLEN-1];
    assign w_sb       = w_b_signed & r_b[XLEN-1];
    assign w_mag_a    = w_sa ? -r_a : r_a;
    assign w_mag_b    = w_sb ? -r_b : r_b;
    assign w_b_zero   = (r_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
    logic w_a_zero;
    logic w_ovf;

    assign w_a_zero = (r_a == '0);
    assign w_ovf    = w_is_div && !r_op[0]
                   && (r_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (r_b == {XLEN{1'b1}});
    assign w_early  = (w_is_div & w_b_zero) | w_ovf | (~w_is_div & (w_a_zero | w_b_zero));
`else
    assign w_early  = 1'b0;
`endif

    // Early divide-by-zero preloads the final {remainder, quotient} pair;
    // overflow and zero multiplies already finish correctly from the normal seed.
    always_comb begin
        w_init_acc = '0;
        if (w_is_div) begin
            if (w_early && w_b_zero) begin
                w_init_acc = {w_mag_a, {XLEN{1'b1}}};
            end else begin
                w_init_acc = {{XLEN{1'b0}}, w_mag_a};
            end
        end
    end

    // Shared adder: add multiplicand to upper half, or subtract the divisor
    // (invert + carry-in) from the shifted partial remainder.
    assign w_rem_sh    = r_acc[2*XLEN-1:XLEN-1];
    assign w_add_x     = w_is_div ? w_rem_sh[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
    assign w_add_y     = w_is_div ? ~r_opb : (r_mplr[0] ? r_opb : '0);
    assign w_add_ci    = w_is_div;
    assign w_sum       = {1'b0, w_add_x} + {1'b0, w_add_y} + {{XLEN{1'b0}}, w_add_ci};
    assign w_no_borrow = w_sum[XLEN] | w_rem_sh[XLEN];

    assign w_div_next = {(w_no_borrow ? w_sum[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_no_borrow};
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Sign correction; a signed divide by zero keeps the all-ones quotient.
    assign w_acc_neg = -r_acc;
    assign w_prod    = r_qneg ? w_acc_neg : r_acc;
    assign w_quot    = (r_qneg && !r_dz) ? w_acc_neg[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem     = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = w_rem;
        case (r_op)
            3'b000:                 w_fix_result = r_acc[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_result = w_quot;
            default:                w_fix_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_opb    <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
        end else if (bus.flush && (r_state != c_IDLE)) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_op    <= bus.Funct3;
                        r_a     <= bus.SrcA;
                        r_b     <= bus.SrcB;
                        r_state <= c_PREP;
                    end
                end
                c_PREP: begin
                    r_opb   <= w_mag_b;
                    r_mplr  <= w_mag_a;
                    r_acc   <= w_init_acc;
                    r_cnt   <= '0;
                    r_qneg  <= w_sa ^ w_sb;
                    r_rneg  <= w_sa;
                    r_dz    <= w_is_div & w_b_zero;
                    r_state <= w_early ? c_FIX : c_CALC;
                end
                c_CALC: begin
                    r_acc  <= w_is_div ? w_div_next : w_mul_next;
                    r_mplr <= r_mplr >> 1;
                    r_cnt  <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_result <= w_fix_result;
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state != c_IDLE);
    assign bus.done   = (r_state == c_DONE);
    assign bus.Result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed vector table plus flush, handshake and reset
//               sequences for muldiv_sequencer (with or without
//               MULDIV_EARLY_OUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam int c_FULL_LAT = XLEN + 3;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit c_EARLY_ON = 1'b1;
`else
    localparam bit c_EARLY_ON = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    muldiv_sequencer_if #(.XLEN(XLEN)) bif ();

    muldiv_sequencer #(.XLEN(XLEN)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          early;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge with the DUT idle; returns at #1 after the
    // edge that raised done. lat counts the sampling edge as 1.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        bif.Funct3 = op;
        bif.SrcA   = a;
        bif.SrcB   = b;
        bif.start  = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        lat = 1;
        while (!bif.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bif.Result;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] res;
        int          ndone;
        int          first_i;
        int          second_i;
        logic [31:0] res1;
        logic [31:0] res2;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{"mul_m1x2",        3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{"mulh_m1x2",       3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{"mulhu_m1x2",      3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0};
        vecs[3]  = '{"mulhsu_m1x2",     3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"mul_mixed",       3'b000, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b0};
        vecs[5]  = '{"mulhu_mixed",     3'b011, 32'h00010003, 32'h00020005, 32'h00000002, 1'b0};
        vecs[6]  = '{"mulh_min_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[7]  = '{"mulhsu_min_max",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[8]  = '{"mulhu_min_max",   3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0};
        vecs[9]  = '{"div_m7_2",        3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{"rem_m7_2",        3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{"divu_m7_2",       3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0};
        vecs[12] = '{"remu_m7_2",       3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 1'b0};
        vecs[13] = '{"div_100_m7",      3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
        vecs[14] = '{"rem_100_m7",      3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 1'b0};
        vecs[15] = '{"divu_by0",        3'b101, 32'h00000055, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[16] = '{"rem_by0",         3'b110, 32'h00001234, 32'h00000000, 32'h00001234, 1'b1};
        vecs[17] = '{"div_neg_by0",     3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[18] = '{"rem_neg_by0",     3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1};
        vecs[19] = '{"remu_by0",        3'b111, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1};
        vecs[20] = '{"div_ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[21] = '{"rem_ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[22] = '{"mul_zero_a",      3'b000, 32'h00000000, 32'h00012345, 32'h00000000, 1'b1};
        vecs[23] = '{"mulh_zero_b",     3'b001, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b1};
        vecs[24] = '{"divu_min_max",    3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};

        reset_n    = 1'b0;
        bif.start  = 1'b0;
        bif.flush  = 1'b0;
        bif.Funct3 = 3'b000;
        bif.SrcA   = '0;
        bif.SrcB   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, bif.busy}, 32'd0);
        check("reset_done",   {31'd0, bif.done}, 32'd0);
        check("reset_result", bif.Result,        32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat,
                  (vecs[i].early && c_EARLY_ON) ? 32'd3 : 32'(c_FULL_LAT));
            @(posedge clk); #1;
            check({vecs[i].name, "_idle_after"}, {30'd0, bif.busy, bif.done}, 32'd0);
        end

        // Flush at CALC counter 10: no done pulse, Result held.
        run_op(3'b000, 32'h00010003, 32'h00020005, lat, res);
        @(posedge clk); #1;
        bif.Funct3 = 3'b100;
        bif.SrcA   = 32'd100;
        bif.SrcB   = 32'd7;
        bif.start  = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (bif.done) ndone++;
        end
        check("flush_busy_before", {31'd0, bif.busy}, 32'd1);
        bif.flush = 1'b1;
        @(posedge clk); #1;
        bif.flush = 1'b0;
        check("flush_busy_after",  {31'd0, bif.busy}, 32'd0);
        check("flush_done_after",  {31'd0, bif.done}, 32'd0);
        check("flush_no_done",     ndone,             32'd0);
        check("flush_result_held", bif.Result,        32'h000B000F);
        @(posedge clk); #1;
        run_op(3'b100, 32'd100, 32'd7, lat, res);
        check("post_flush_result",  res, 32'd14);
        check("post_flush_latency", lat, 32'(c_FULL_LAT));
        @(posedge clk); #1;

        // flush together with start in IDLE drops the request.
        bif.Funct3 = 3'b000;
        bif.start  = 1'b1;
        bif.flush  = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        bif.flush = 1'b0;
        check("idle_flush_start_busy", {31'd0, bif.busy}, 32'd0);
        @(posedge clk); #1;
        check("idle_flush_start_held", bif.Result, 32'd14);

        // start held high for 40 cycles; operands change mid-CALC.
        bif.Funct3 = 3'b101;
        bif.SrcA   = 32'd100;
        bif.SrcB   = 32'd7;
        bif.start  = 1'b1;
        ndone    = 0;
        first_i  = 0;
        second_i = 0;
        res1     = '0;
        res2     = '0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (bif.done) begin
                ndone++;
                if (ndone == 1) begin
                    first_i = i;
                    res1    = bif.Result;
                end else if (ndone == 2) begin
                    second_i = i;
                    res2     = bif.Result;
                end
            end
            if (i == 36) check("hs_idle_gap", {31'd0, bif.busy}, 32'd0);
            if (i == 10) begin
                bif.SrcA = 32'd200;
                bif.SrcB = 32'd3;
            end
            if (i == 38) begin
                bif.SrcA   = 32'd5;
                bif.SrcB   = 32'd5;
                bif.Funct3 = 3'b000;
            end
            if (i == 40) bif.start = 1'b0;
        end
        check("hs_done_count",  ndone,    32'd2);
        check("hs_first_done",  first_i,  32'(c_FULL_LAT));
        check("hs_first_res",   res1,     32'd14);
        check("hs_second_done", second_i, 32'(c_FULL_LAT + 36));
        check("hs_second_res",  res2,     32'd66);

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        bif.Funct3 = 3'b000;
        bif.SrcA   = 32'h00000003;
        bif.SrcB   = 32'h00000005;
        bif.start  = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_calc_busy", {31'd0, bif.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_busy",   {31'd0, bif.busy}, 32'd0);
        check("async_reset_done",   {31'd0, bif.done}, 32'd0);
        check("async_reset_result", bif.Result,        32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
